// File: rtl/conv_ctrl_param.sv
// Loop/address sequencer for a convolution layer: walks kx, ky, ic, ox, oy, oc
// (innermost first) and times read, accumulator-clear and write strobes for the MAC path.
module conv_ctrl_param #(
  parameter int K       = 5,
  parameter int IN_W    = 32,
  parameter int IN_H    = 32,
  parameter int OUT_W   = 28,
  parameter int OUT_H   = 28,
  parameter int STRIDE  = 1,
  parameter int N_CH    = 1,
  parameter int N_OC    = 6,
  parameter int FA_W    = 12,
  parameter int WA_W    = 10,
  parameter int OA_W    = 13,
  parameter int CLR_DLY = 6,
  parameter int WR_DLY  = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            abort,
  output logic [FA_W-1:0] f_raddr,
  output logic [WA_W-1:0] w_raddr,
  output logic            rd_vld,
  output logic            acc_clr,
  output logic [OA_W-1:0] o_waddr,
  output logic            o_wr_en,
  output logic            conv_done,
  output logic            busy
);

  localparam int CW = 16;

  localparam logic [CW-1:0] KX_LAST = CW'(K - 1);
  localparam logic [CW-1:0] IC_LAST = CW'(N_CH - 1);
  localparam logic [CW-1:0] OX_LAST = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_LAST = CW'(OUT_H - 1);
  localparam logic [CW-1:0] OC_LAST = CW'(N_OC - 1);

  localparam logic [FA_W-1:0] F_KY_STEP = FA_W'(IN_W);
  localparam logic [FA_W-1:0] F_IC_STEP = FA_W'(IN_H * IN_W);
  localparam logic [FA_W-1:0] F_OX_STEP = FA_W'(STRIDE);
  localparam logic [FA_W-1:0] F_OY_STEP = FA_W'(STRIDE * IN_W);
  localparam logic [WA_W-1:0] W_KY_STEP = WA_W'(K);
  localparam logic [WA_W-1:0] W_IC_STEP = WA_W'(K * K);
  localparam logic [WA_W-1:0] W_OC_STEP = WA_W'(N_CH * K * K);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    FLUSH = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] kx, ky, ic, ox, oy, oc;
  logic [FA_W-1:0] f_ky_base, f_ic_base, f_ox_base, f_oy_base;
  logic [WA_W-1:0] w_ky_base, w_ic_base, w_oc_base;

  logic issue, launch, last_issue, clr_in, wr_in, wr_tail_empty;
  logic kx_wrap, ky_wrap, ic_wrap, ox_wrap, oy_wrap, oc_wrap;
  logic adv_ky, adv_ic, adv_ox, adv_oy, adv_oc;

  logic [FA_W-1:0] f_part_a, f_part_b;
  logic [WA_W-1:0] w_part_a, w_part_b;
  logic            vld_p1;

  logic [CLR_DLY:1] clr_line;
  logic [WR_DLY:1]  wr_line;
  logic [OA_W-1:0]  wr_cnt;

  assign issue  = (state == RUN) && !stall && !abort;
  assign launch = (state == IDLE) && start && !abort;

  assign kx_wrap = (kx == KX_LAST);
  assign ky_wrap = (ky == KX_LAST);
  assign ic_wrap = (ic == IC_LAST);
  assign ox_wrap = (ox == OX_LAST);
  assign oy_wrap = (oy == OY_LAST);
  assign oc_wrap = (oc == OC_LAST);

  assign adv_ky     = issue && kx_wrap;
  assign adv_ic     = adv_ky && ky_wrap;
  assign adv_ox     = adv_ic && ic_wrap;
  assign adv_oy     = adv_ox && ox_wrap;
  assign adv_oc     = adv_oy && oy_wrap;
  assign last_issue = adv_oc && oc_wrap;

  assign clr_in = issue && (kx == '0) && (ky == '0) && (ic == '0);
  assign wr_in  = adv_ox;

  // Each counter carries a matching address offset so no multiply is needed per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0; ky <= '0; ic <= '0; ox <= '0; oy <= '0; oc <= '0;
      f_ky_base <= '0; f_ic_base <= '0; f_ox_base <= '0; f_oy_base <= '0;
      w_ky_base <= '0; w_ic_base <= '0; w_oc_base <= '0;
    end else if (abort) begin
      kx <= '0; ky <= '0; ic <= '0; ox <= '0; oy <= '0; oc <= '0;
      f_ky_base <= '0; f_ic_base <= '0; f_ox_base <= '0; f_oy_base <= '0;
      w_ky_base <= '0; w_ic_base <= '0; w_oc_base <= '0;
    end else if (issue) begin
      kx <= kx_wrap ? '0 : kx + CW'(1);
      if (adv_ky) begin
        ky        <= ky_wrap ? '0 : ky + CW'(1);
        f_ky_base <= ky_wrap ? '0 : f_ky_base + F_KY_STEP;
        w_ky_base <= ky_wrap ? '0 : w_ky_base + W_KY_STEP;
      end
      if (adv_ic) begin
        ic        <= ic_wrap ? '0 : ic + CW'(1);
        f_ic_base <= ic_wrap ? '0 : f_ic_base + F_IC_STEP;
        w_ic_base <= ic_wrap ? '0 : w_ic_base + W_IC_STEP;
      end
      if (adv_ox) begin
        ox        <= ox_wrap ? '0 : ox + CW'(1);
        f_ox_base <= ox_wrap ? '0 : f_ox_base + F_OX_STEP;
      end
      if (adv_oy) begin
        oy        <= oy_wrap ? '0 : oy + CW'(1);
        f_oy_base <= oy_wrap ? '0 : f_oy_base + F_OY_STEP;
      end
      if (adv_oc) begin
        oc        <= oc_wrap ? '0 : oc + CW'(1);
        w_oc_base <= oc_wrap ? '0 : w_oc_base + W_OC_STEP;
      end
    end
  end

  // Two-stage address adder; addresses hold through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_part_a <= '0; f_part_b <= '0;
      w_part_a <= '0; w_part_b <= '0;
      vld_p1   <= 1'b0;
      rd_vld   <= 1'b0;
      f_raddr  <= '0;
      w_raddr  <= '0;
    end else begin
      vld_p1 <= issue;
      rd_vld <= vld_p1 && !abort;
      if (issue) begin
        f_part_a <= f_ic_base + f_oy_base;
        f_part_b <= f_ky_base + f_ox_base + FA_W'(kx);
        w_part_a <= w_oc_base + w_ic_base;
        w_part_b <= w_ky_base + WA_W'(kx);
      end
      if (vld_p1 && !abort) begin
        f_raddr <= f_part_a + f_part_b;
        w_raddr <= w_part_a + w_part_b;
      end
    end
  end

  // Pixels complete in ox, oy, oc order, so the write address is simply the write ordinal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_line <= '0;
      wr_line  <= '0;
      wr_cnt   <= '0;
      o_waddr  <= '0;
    end else if (abort) begin
      clr_line <= '0;
      wr_line  <= '0;
      wr_cnt   <= '0;
    end else begin
      clr_line[1] <= clr_in;
      for (int i = 2; i <= CLR_DLY; i++) clr_line[i] <= clr_line[i-1];
      wr_line[1] <= wr_in;
      for (int i = 2; i <= WR_DLY; i++) wr_line[i] <= wr_line[i-1];
      if (launch) begin
        wr_cnt <= '0;
      end else if (wr_line[WR_DLY-1]) begin
        o_waddr <= wr_cnt;
        wr_cnt  <= wr_cnt + OA_W'(1);
      end
    end
  end

  assign acc_clr       = clr_line[CLR_DLY];
  assign o_wr_en       = wr_line[WR_DLY];
  assign wr_tail_empty = (wr_line[WR_DLY-1:1] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    conv_done  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_issue) state_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (o_wr_en && wr_tail_empty) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        conv_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

endmodule

// File: tb/tb_conv_ctrl_param.sv
// Directed bench for conv_ctrl_param: a 3x3/2ch/2map instance and a 2x2 stride-2 instance.
module tb_conv_ctrl_param;

  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic rst_n, start, stall, abort;
  logic start3, stall3, abort3;

  logic [11:0] f_raddr, f_raddr3;
  logic [9:0]  w_raddr, w_raddr3;
  logic [12:0] o_waddr, o_waddr3;
  logic rd_vld, acc_clr, o_wr_en, conv_done, busy;
  logic rd_vld3, acc_clr3, o_wr_en3, conv_done3, busy3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [11:0] f_q[$];
  logic [9:0]  w_q[$];
  logic [12:0] wa_q[$];
  int vcyc_q[$], wcyc_q[$], clr_q[$], done_q[$];
  logic [11:0] f3_q[$];
  int wr3_q[$];
  logic stall_hist[HIST];
  logic vld_hist[HIST];
  logic busy_hist[HIST];

  always #5 clk = ~clk;

  conv_ctrl_param #(.K(3), .IN_W(6), .IN_H(6), .OUT_W(4), .OUT_H(4), .STRIDE(1),
                    .N_CH(2), .N_OC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
    .f_raddr(f_raddr), .w_raddr(w_raddr), .rd_vld(rd_vld), .acc_clr(acc_clr),
    .o_waddr(o_waddr), .o_wr_en(o_wr_en), .conv_done(conv_done), .busy(busy)
  );

  conv_ctrl_param #(.K(2), .IN_W(8), .IN_H(8), .OUT_W(4), .OUT_H(4), .STRIDE(2),
                    .N_CH(1), .N_OC(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stall(stall3), .abort(abort3),
    .f_raddr(f_raddr3), .w_raddr(w_raddr3), .rd_vld(rd_vld3), .acc_clr(acc_clr3),
    .o_waddr(o_waddr3), .o_wr_en(o_wr_en3), .conv_done(conv_done3), .busy(busy3)
  );

  always @(posedge clk) begin
    stall_hist[cyc % HIST] <= stall;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    vld_hist[cyc % HIST]  <= rd_vld;
    busy_hist[cyc % HIST] <= busy;
    if (rd_vld) begin
      f_q.push_back(f_raddr);
      w_q.push_back(w_raddr);
      vcyc_q.push_back(cyc);
    end
    if (o_wr_en) begin
      wa_q.push_back(o_waddr);
      wcyc_q.push_back(cyc);
    end
    if (acc_clr)   clr_q.push_back(cyc);
    if (conv_done) done_q.push_back(cyc);
    if (rd_vld3)   f3_q.push_back(f_raddr3);
    if (o_wr_en3)  wr3_q.push_back(cyc);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference addresses for issue number i of the 3x3, 6x6-in, 4x4-out, 2ch, 2map layer.
  function automatic int exp_f(input int i);
    int kx, ky, ic, ox, oy;
    kx = i % 3; ky = (i / 3) % 3; ic = (i / 9) % 2; ox = (i / 18) % 4; oy = (i / 72) % 4;
    return ic * 36 + (oy + ky) * 6 + ox + kx;
  endfunction

  function automatic int exp_w(input int i);
    int kx, ky, ic, oc;
    kx = i % 3; ky = (i / 3) % 3; ic = (i / 9) % 2; oc = i / 288;
    return ((oc * 2 + ic) * 3 + ky) * 3 + kx;
  endfunction

  task automatic wait_done(input string tag, input int db, input int bound, input bit rnd);
    for (int i = 0; i < bound; i++) begin
      if (done_q.size() > db) break;
      stall = rnd ? ($urandom_range(0, 99) < 30) : 1'b0;
      step();
    end
    stall = 1'b0;
    check({tag, "_done_seen"}, done_q.size() > db, 1);
  endtask

  task automatic wait_issues(input string tag, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (f_q.size() >= target) break;
      step();
    end
    check({tag, "_issues_reached"}, f_q.size() >= target, 1);
  endtask

  task automatic check_stream(input string tag, input int vb, input int wb);
    int n, nw;
    n  = f_q.size() - vb;
    nw = wa_q.size() - wb;
    check({tag, "_issue_count"}, n, 576);
    check({tag, "_write_count"}, nw, 32);
    for (int i = 0; i < n && i < 576; i++) begin
      check($sformatf("%s_f[%0d]", tag, i), f_q[vb + i], exp_f(i));
      check($sformatf("%s_w[%0d]", tag, i), w_q[vb + i], exp_w(i));
    end
    for (int i = 0; i < nw && i < 32; i++)
      check($sformatf("%s_waddr[%0d]", tag, i), wa_q[wb + i], i);
  endtask

  initial begin
    int vb, wb, cb, db, n, nw, c0, c1, vcnt, wcnt, ccnt, dcnt;

    rst_n = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    start3 = 1'b0; stall3 = 1'b0; abort3 = 1'b0;
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_o_wr_en", o_wr_en, 0);
    check("rst_conv_done", conv_done, 0);
    rst_n = 1'b1;
    step();

    // Run 1: no stall, both instances launched together
    vb = f_q.size(); wb = wa_q.size(); cb = clr_q.size(); db = done_q.size();
    start = 1'b1; start3 = 1'b1;
    check("idle_busy", busy, 0);
    step();
    start = 1'b0; start3 = 1'b0;
    check("busy_after_start", busy, 1);
    wait_done("run1", db, 2000, 1'b0);
    step(); step();
    check_stream("run1", vb, wb);
    check("run1_f18", f_q[vb + 17], 50);
    check("run1_w18", w_q[vb + 17], 17);
    check("run1_f19", f_q[vb + 18], 1);
    check("run1_w19", w_q[vb + 18], 0);
    nw = wa_q.size() - wb;
    check("run1_first_write_lat", wcyc_q[wb], vcyc_q[vb] + 24);
    check("run1_clr_count", clr_q.size() - cb, 32);
    check("run1_clr0_lat", clr_q[cb], vcyc_q[vb] + 4);
    check("run1_clr1_lat", clr_q[cb + 1], vcyc_q[vb + 18] + 4);
    check("run1_done_after_last_wr", done_q[db], wcyc_q[wb + nw - 1] + 1);
    check("run1_busy_at_done", busy_hist[done_q[db] % HIST], 1);
    check("run1_busy_after_done", busy_hist[(done_q[db] + 1) % HIST], 0);

    check("cfg3_issue_count", f3_q.size(), 64);
    check("cfg3_write_count", wr3_q.size(), 16);
    check("cfg3_px1_tap0", f3_q[4], 2);
    check("cfg3_px1_tap1", f3_q[5], 3);
    check("cfg3_px1_tap2", f3_q[6], 10);
    check("cfg3_px1_tap3", f3_q[7], 11);
    check("cfg3_row1_tap0", f3_q[16], 16);

    // Run 2: random stall; same streams, bubbles two cycles after each stalled issue cycle
    vb = f_q.size(); wb = wa_q.size(); db = done_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("run2", db, 3000, 1'b1);
    step(); step();
    check_stream("run2", vb, wb);
    n = f_q.size() - vb;
    if (n > 0) begin
      c0 = vcyc_q[vb] - 2;
      c1 = vcyc_q[vb + n - 1] - 2;
      for (int c = c0; c <= c1; c++)
        check($sformatf("run2_bubble_c%0d", c), vld_hist[(c + 2) % HIST], !stall_hist[c % HIST]);
    end

    // Run 3: abort after ~100 issues
    vb = f_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_issues("abort", vb + 100, 500);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    vcnt = f_q.size(); wcnt = wa_q.size(); ccnt = clr_q.size(); dcnt = done_q.size();
    repeat (40) step();
    check("abort_no_rd_vld", f_q.size(), vcnt);
    check("abort_no_wr", wa_q.size(), wcnt);
    check("abort_no_clr", clr_q.size(), ccnt);
    check("abort_no_done", done_q.size(), dcnt);

    // Run 4: restart after abort, with a start pulse mid-run that must be ignored
    vb = f_q.size(); wb = wa_q.size(); db = done_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("run4", db, 2000, 1'b0);
    repeat (5) step();
    check("run4_first_f", f_q[vb], 0);
    check("run4_first_w", w_q[vb], 0);
    check("run4_first_waddr", wa_q[wb], 0);
    check("run4_issue_count", f_q.size() - vb, 576);
    check("run4_write_count", wa_q.size() - wb, 32);
    check("run4_single_done", done_q.size() - db, 1);
    check("run4_idle_busy", busy, 0);

    // Run 5: async reset in FLUSH, then a clean run
    vb = f_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_issues("flush", vb + 576, 1000);
    step();
    check("flush_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_f", f_raddr, 0);
    check("rst_async_w", w_raddr, 0);
    check("rst_async_waddr", o_waddr, 0);
    check("rst_async_wr_en", o_wr_en, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    vb = f_q.size(); wb = wa_q.size(); db = done_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("run5", db, 2000, 1'b0);
    step(); step();
    check_stream("run5", vb, wb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
